pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_pkg.sv | 29 ++
 rtl/pc_unit_npc_calc.sv | 55 +++++
 rtl/pc_unit.sv | 104 ++++++++++
 tb/tb_pc_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg -- shared pipeline constants for the program-counter unit.
// Holds the next-PC select encodings, the reset/exception vectors, the
// legal text-segment window and a helper that classifies a fetch address.
package pc_unit_pkg;

    // Next-PC select carried with the instruction in D.
    typedef enum logic [2:0] {
        NPC_SEQ = 3'b000,
        NPC_BR  = 3'b001,
        NPC_J   = 3'b010,
        NPC_JR  = 3'b011
    } npc_op_e;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;

    // True when a fetch address is misaligned or outside the text segment.
    function automatic logic fetch_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < TEXT_LO) || (addr > TEXT_HI);
    endfunction

    // True when the select code names a control-transfer instruction.
    function automatic logic is_cti(input logic [2:0] op);
        return (op == NPC_BR) || (op == NPC_J) || (op == NPC_JR);
    endfunction

endpackage

// File: rtl/pc_unit_npc_calc.sv
// npc_calc -- purely combinational next-PC target selection.
// Ports:
//   pc      : current fetch address (F)
//   pcd     : address of the instruction in D
//   op      : next-PC select for the D instruction
//   br      : branch-taken flag (only meaningful when op selects a branch)
//   imm26   : instr[25:0] of the D instruction
//   reg_rs  : forwarded rs value, the register-jump target
//   npc     : selected next fetch address when no stall/exception/eret
//   pc8     : pcd + 8, the link value
module npc_calc
    import pc_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pcd,
    input  logic [2:0]  op,
    input  logic        br,
    input  logic [25:0] imm26,
    input  logic [31:0] reg_rs,
    output logic [31:0] npc,
    output logic [31:0] pc8
);

    logic [31:0] seq_s;
    logic [31:0] br_s;
    logic [31:0] j_s;
    logic [31:0] off_s;

    // Candidate targets; all adds wrap modulo 2^32, faults are caught by AdEL.
    always_comb begin
        seq_s = pc + 32'd4;
        off_s = {{14{imm26[15]}}, imm26[15:0], 2'b00};
        br_s  = pcd + 32'd4 + off_s;
        j_s   = {pcd[31:28], imm26, 2'b00};
        pc8   = pcd + 32'd8;
    end

    // Target selection; Br only matters for the branch encoding.
    always_comb begin
        npc = seq_s;
        case (op)
            NPC_BR: begin
                if (br) begin
                    npc = br_s;
                end else begin
                    npc = seq_s;
                end
            end
            NPC_J:   npc = j_s;
            NPC_JR:  npc = reg_rs;
            default: npc = seq_s;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit -- fetch PC register plus the D-stage PC / delay-slot flag.
// Ports:
//   clk, reset     : clock; synchronous active-low reset
//   Stall          : hazard stall, holds PC, PCD and BD
//   Op, Br         : next-PC select and branch-taken flag for the D instruction
//   Imm26, RegRs   : jump/branch immediate field and register-jump target
//   ExcReq, Eret   : exception redirect and eret commit (both flush D)
//   EPC            : return address used by eret
//   PC, PCD, PC8   : fetch address, D-instruction address, link value
//   BD             : D instruction sits in a delay slot
//   AdEL           : fetch-address fault flag for PC
module pc_unit
    import pc_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [2:0]  Op,
    input  logic        Br,
    input  logic [25:0] Imm26,
    input  logic [31:0] RegRs,
    input  logic        ExcReq,
    input  logic        Eret,
    input  logic [31:0] EPC,
    output logic [31:0] PC,
    output logic [31:0] PCD,
    output logic [31:0] PC8,
    output logic        BD,
    output logic        AdEL
);

    logic [31:0] pc_r;
    logic [31:0] pcd_r;
    logic        bd_r;
    logic [31:0] npc_s;
    logic [31:0] pc_next_s;
    logic [31:0] pcd_next_s;
    logic        bd_next_s;
    logic        adel_s;

    npc_calc u_npc_calc (
        .pc     (pc_r),
        .pcd    (pcd_r),
        .op     (Op),
        .br     (Br),
        .imm26  (Imm26),
        .reg_rs (RegRs),
        .npc    (npc_s),
        .pc8    (PC8)
    );

    // Fetch-address fault on the current PC.
    always_comb begin
        adel_s = fetch_fault(pc_r);
    end

    // Next-state selection: exception beats eret beats stall beats fault-hold.
    // A faulting PC freezes fetch, but D still advances so the pipe drains.
    always_comb begin
        pc_next_s  = pc_r;
        pcd_next_s = pcd_r;
        bd_next_s  = bd_r;
        if (ExcReq) begin
            pc_next_s  = EXC_PC;
            pcd_next_s = 32'h0000_0000;
            bd_next_s  = 1'b0;
        end else if (Eret) begin
            pc_next_s  = EPC;
            pcd_next_s = 32'h0000_0000;
            bd_next_s  = 1'b0;
        end else if (Stall) begin
            pc_next_s  = pc_r;
            pcd_next_s = pcd_r;
            bd_next_s  = bd_r;
        end else begin
            if (adel_s) begin
                pc_next_s = pc_r;
            end else begin
                pc_next_s = npc_s;
            end
            pcd_next_s = pc_r;
            bd_next_s  = is_cti(Op);
        end
    end

    // PC, PCD and BD registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r  <= RESET_PC;
            pcd_r <= 32'h0000_0000;
            bd_r  <= 1'b0;
        end else begin
            pc_r  <= pc_next_s;
            pcd_r <= pcd_next_s;
            bd_r  <= bd_next_s;
        end
    end

    assign PC   = pc_r;
    assign PCD  = pcd_r;
    assign BD   = bd_r;
    assign AdEL = adel_s;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- scoreboard bench for pc_unit. Each step drives one cycle of
// inputs and pushes the hand-derived expected state; after the edge the
// expectation is popped and compared against the outputs.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic [2:0]  Op;
    logic        Br;
    logic [25:0] Imm26;
    logic [31:0] RegRs;
    logic        ExcReq;
    logic        Eret;
    logic [31:0] EPC;
    logic [31:0] PC;
    logic [31:0] PCD;
    logic [31:0] PC8;
    logic        BD;
    logic        AdEL;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] pcd;
        logic        bd;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    pc_unit dut (
        .clk    (clk),
        .reset  (reset),
        .Stall  (Stall),
        .Op     (Op),
        .Br     (Br),
        .Imm26  (Imm26),
        .RegRs  (RegRs),
        .ExcReq (ExcReq),
        .Eret   (Eret),
        .EPC    (EPC),
        .PC     (PC),
        .PCD    (PCD),
        .PC8    (PC8),
        .BD     (BD),
        .AdEL   (AdEL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, queue expectation, clock, pop and compare.
    task automatic step(input string tag, input logic rst, input logic stl,
                        input logic [2:0] op, input logic br, input logic [25:0] imm,
                        input logic [31:0] rs, input logic exc, input logic er,
                        input logic [31:0] epc, input logic [31:0] e_pc,
                        input logic [31:0] e_pcd, input logic e_bd, input logic e_adel);
        exp_t e;
        exp_t g;
        reset  = rst;
        Stall  = stl;
        Op     = op;
        Br     = br;
        Imm26  = imm;
        RegRs  = rs;
        ExcReq = exc;
        Eret   = er;
        EPC    = epc;
        e.tag  = tag;
        e.pc   = e_pc;
        e.pcd  = e_pcd;
        e.bd   = e_bd;
        e.adel = e_adel;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            g = exp_q.pop_front();
            check_val({g.tag, "_pc"},   PC,  g.pc);
            check_val({g.tag, "_pcd"},  PCD, g.pcd);
            check_val({g.tag, "_pc8"},  PC8, g.pcd + 32'd8);
            check_val({g.tag, "_bd"},   {31'd0, BD},   {31'd0, g.bd});
            check_val({g.tag, "_adel"}, {31'd0, AdEL}, {31'd0, g.adel});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0; Stall = 1'b0; Op = 3'b000; Br = 1'b0; Imm26 = 26'd0;
        RegRs = 32'd0; ExcReq = 1'b0; Eret = 1'b0; EPC = 32'd0;

        //    tag        rst   stl   op      br    imm26          rs             exc   eret  epc            PC             PCD            BD    AdEL
        step("rst",      1'b0, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3000, 32'h0000_0000, 1'b0, 1'b0);
        step("seq1",     1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3004, 32'h0000_3000, 1'b0, 1'b0);
        step("seq2",     1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3008, 32'h0000_3004, 1'b0, 1'b0);
        step("seq3",     1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_300C, 32'h0000_3008, 1'b0, 1'b0);
        step("seq4",     1'b1, 1'b0, 3'b111, 1'b1, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3010, 32'h0000_300C, 1'b0, 1'b0);
        step("seq5",     1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3014, 32'h0000_3010, 1'b0, 1'b0);
        step("beq_t",    1'b1, 1'b0, 3'b001, 1'b1, 26'h000_0003,  32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3020, 32'h0000_3014, 1'b1, 1'b0);
        step("after_b",  1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3024, 32'h0000_3020, 1'b0, 1'b0);
        step("beq_nt",   1'b1, 1'b0, 3'b001, 1'b0, 26'h000_0040,  32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3028, 32'h0000_3024, 1'b1, 1'b0);
        step("jr",       1'b1, 1'b0, 3'b011, 1'b0, 26'd0,         32'h0000_3100, 1'b0, 1'b0, 32'd0,         32'h0000_3100, 32'h0000_3028, 1'b1, 1'b0);
        step("stall1",   1'b1, 1'b1, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3100, 32'h0000_3028, 1'b1, 1'b0);
        step("stall2",   1'b1, 1'b1, 3'b001, 1'b1, 26'h000_0010,  32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3100, 32'h0000_3028, 1'b1, 1'b0);
        step("unstall",  1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3104, 32'h0000_3100, 1'b0, 1'b0);
        step("j",        1'b1, 1'b0, 3'b010, 1'b0, 26'h000_0C80,  32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3200, 32'h0000_3104, 1'b1, 1'b0);
        step("br_ign",   1'b1, 1'b0, 3'b000, 1'b1, 26'h000_0100,  32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3204, 32'h0000_3200, 1'b0, 1'b0);
        step("exc_all",  1'b1, 1'b1, 3'b011, 1'b1, 26'd0,         32'h0000_3100, 1'b1, 1'b1, 32'h0000_5000, 32'h0000_4180, 32'h0000_0000, 1'b0, 1'b0);
        step("post_exc", 1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_4184, 32'h0000_4180, 1'b0, 1'b0);
        step("eret",     1'b1, 1'b1, 3'b010, 1'b0, 26'h000_0C80,  32'd0,         1'b0, 1'b1, 32'h0000_3008, 32'h0000_3008, 32'h0000_0000, 1'b0, 1'b0);
        step("post_er",  1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_300C, 32'h0000_3008, 1'b0, 1'b0);
        step("jr_bad",   1'b1, 1'b0, 3'b011, 1'b0, 26'd0,         32'h0000_3002, 1'b0, 1'b0, 32'd0,         32'h0000_3002, 32'h0000_300C, 1'b1, 1'b1);
        step("hold1",    1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3002, 32'h0000_3002, 1'b0, 1'b1);
        step("hold2",    1'b1, 1'b0, 3'b011, 1'b0, 26'd0,         32'h0000_3100, 1'b0, 1'b0, 32'd0,         32'h0000_3002, 32'h0000_3002, 1'b1, 1'b1);
        step("exc_fix",  1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b1, 1'b0, 32'd0,         32'h0000_4180, 32'h0000_0000, 1'b0, 1'b0);
        step("seq6",     1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_4184, 32'h0000_4180, 1'b0, 1'b0);
        step("b_back",   1'b1, 1'b0, 3'b001, 1'b1, 26'h000_FFFE,  32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_417C, 32'h0000_4184, 1'b1, 1'b0);
        step("jr_hi",    1'b1, 1'b0, 3'b011, 1'b0, 26'd0,         32'h0000_6FFC, 1'b0, 1'b0, 32'd0,         32'h0000_6FFC, 32'h0000_417C, 1'b1, 1'b0);
        step("over_hi",  1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_7000, 32'h0000_6FFC, 1'b0, 1'b1);
        step("hold_hi",  1'b1, 1'b0, 3'b011, 1'b0, 26'd0,         32'h0000_2FFC, 1'b0, 1'b0, 32'd0,         32'h0000_7000, 32'h0000_7000, 1'b1, 1'b1);
        step("rst_mid",  1'b0, 1'b0, 3'b011, 1'b1, 26'd0,         32'h0000_3100, 1'b0, 1'b0, 32'd0,         32'h0000_3000, 32'h0000_0000, 1'b0, 1'b0);
        step("post_rst", 1'b1, 1'b0, 3'b000, 1'b0, 26'd0,         32'd0,         1'b0, 1'b0, 32'd0,         32'h0000_3004, 32'h0000_3000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
